// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer, the instruction memory and decode.
// The master modport is the fetch sequencer side; the slave modport is the memory/decode side.
interface fetch_sequencer_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, tracks one in-flight memory read and buffers
// returned instructions for decode. Define FETCH_PERF_CNT_EN to add issue/stall counters.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  fetch_sequencer_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_issue_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      r_pc;
  logic [63:0]      r_reqPc;
  logic             r_pending;
  logic [31:0]      r_fifoInst [BUF_DEPTH];
  logic [63:0]      r_fifoPc   [BUF_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_outValid;

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_inFlight;
  logic [CNT_W-1:0] w_countNext;

  assign w_pop  = r_outValid & bus.out_ready;
  assign w_push = r_pending & ~bus.redirect_valid;

  // Buffered plus in-flight entries left after this edge's pop; a new read may only be
  // issued while that total still leaves room, so a later push can never overflow.
  assign w_inFlight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pending} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue    = ~bus.redirect_valid & (w_inFlight < (CNT_W + 1)'(BUF_DEPTH));

  always_comb begin
    w_countNext = r_count;
    if (bus.redirect_valid) begin
      w_countNext = '0;
    end else if (w_push && !w_pop) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_reqPc    <= '0;
      r_pending  <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_outValid <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_fifoInst[i] <= '0;
        r_fifoPc[i]   <= '0;
      end
    end else begin
      // Redirect wins: the in-flight response and all buffered entries are dropped.
      if (bus.redirect_valid) begin
        r_pc      <= bus.redirect_pc & ~64'h3;
        r_pending <= 1'b0;
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
      end else begin
        if (w_issue) begin
          r_reqPc   <= r_pc;
          r_pending <= 1'b1;
          r_pc      <= r_pc + 64'd4;
        end else begin
          r_pending <= 1'b0;
        end
        if (w_push) begin
          r_fifoInst[r_wrPtr] <= bus.imem_inst;
          r_fifoPc[r_wrPtr]   <= r_reqPc;
          r_wrPtr             <= r_wrPtr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
      end
      r_count    <= w_countNext;
      r_outValid <= (w_countNext != '0);
    end
  end

  assign bus.imem_addr = {2'b00, r_pc[63:2]};
  assign bus.out_valid = r_outValid;
  assign bus.out_inst  = r_fifoInst[r_rdPtr];
  assign bus.out_pc    = r_fifoPc[r_rdPtr];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perfIssue;
  logic [31:0] r_perfStall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perfIssue <= '0;
      r_perfStall <= '0;
    end else begin
      if (w_issue) begin
        r_perfIssue <= r_perfIssue + 32'd1;
      end
      if (r_outValid && !bus.out_ready) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = r_perfIssue;
  assign perf_stall_cnt = r_perfStall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a registered-read memory model.
// Hand-written sequences cover the asynchronous reset pulse and the optional perf counters.
module tb_fetch_sequencer;

  logic clock;
  logic reset;
  int   totalCount;
  int   passCount;

  fetch_sequencer_if ifc ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfIssue;
  logic [31:0] perfStall;
`endif

  fetch_sequencer #(
    .RESET_PC  (64'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issue_cnt (perfIssue),
    .perf_stall_cnt (perfStall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    case (a)
      64'd0:   memWord = 32'h66;
      64'd1:   memWord = 32'h60;
      64'd2:   memWord = 32'h62;
      64'd3:   memWord = 32'h63;
      default: memWord = 32'hA000_0000 | a[31:0];
    endcase
  endfunction

  // Single-cycle-read instruction memory: data registered one clock after the address.
  always @(posedge clock) ifc.imem_inst <= memWord(ifc.imem_addr);

  typedef struct {
    logic        first;
    logic        ready;
    logic        redir;
    logic [63:0] redirPc;
    logic        expValid;
    logic [31:0] expInst;
    logic [63:0] expPc;
    logic [63:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic first, input logic ready, input logic redir,
                        input logic [63:0] redirPc, input logic expValid,
                        input logic [31:0] expInst, input logic [63:0] expPc,
                        input logic [63:0] expAddr);
    vec_t v;
    v.first = first;  v.ready = ready;  v.redir = redir;  v.redirPc = redirPc;
    v.expValid = expValid;  v.expInst = expInst;  v.expPc = expPc;  v.expAddr = expAddr;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    ifc.out_ready = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ifc.out_ready      = v.ready;
    ifc.redirect_valid = v.redir;
    ifc.redirect_pc    = v.redirPc;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkVal($sformatf("row%0d out_valid", idx), {63'd0, ifc.out_valid}, {63'd0, v.expValid});
    checkVal($sformatf("row%0d imem_addr", idx), ifc.imem_addr, v.expAddr);
    if (v.expValid) begin
      checkVal($sformatf("row%0d out_inst", idx), {32'd0, ifc.out_inst}, {32'd0, v.expInst});
      checkVal($sformatf("row%0d out_pc", idx), ifc.out_pc, v.expPc);
    end
    if (v.first) begin
      checkVal($sformatf("row%0d reset out_inst", idx), {32'd0, ifc.out_inst}, 64'd0);
      checkVal($sformatf("row%0d reset out_pc", idx), ifc.out_pc, 64'd0);
    end
  endtask

  initial begin
    totalCount = 0;
    passCount  = 0;
    reset = 1'b1;
    ifc.out_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;

    // Streaming from reset, one instruction per clock.
    addRow(1, 1, 0, 0, 0, 0,     0,  0);
    addRow(0, 1, 0, 0, 0, 0,     0,  1);
    addRow(0, 1, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 1, 0, 0, 1, 'h60,  4,  3);
    addRow(0, 1, 0, 0, 1, 'h62,  8,  4);
    addRow(0, 1, 0, 0, 1, 'h63,  12, 5);
    // Five stalled cycles: head holds, fetch stops at two outstanding.
    addRow(1, 1, 0, 0, 0, 0,     0,  0);
    addRow(0, 1, 0, 0, 0, 0,     0,  1);
    addRow(0, 0, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 0, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 0, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 0, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 0, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 1, 0, 0, 1, 'h66,  0,  2);
    addRow(0, 1, 0, 0, 1, 'h60,  4,  3);
    addRow(0, 1, 0, 0, 1, 'h62,  8,  4);
    addRow(0, 1, 0, 0, 1, 'h63,  12, 5);
    // Redirect to 0x0E with a buffered entry and a read in flight.
    addRow(1, 1, 0, 0,     0, 0,            0,    0);
    addRow(0, 1, 0, 0,     0, 0,            0,    1);
    addRow(0, 0, 1, 'h0E,  1, 'h66,         0,    2);
    addRow(0, 1, 0, 0,     0, 0,            0,    3);
    addRow(0, 1, 0, 0,     0, 0,            0,    4);
    addRow(0, 1, 0, 0,     1, 'h63,         'h0C, 5);
    addRow(0, 1, 0, 0,     1, 'hA000_0004,  'h10, 6);
    // Redirect in the same cycle as a pop.
    addRow(1, 1, 0, 0,     0, 0,            0,    0);
    addRow(0, 1, 0, 0,     0, 0,            0,    1);
    addRow(0, 1, 1, 'h40,  1, 'h66,         0,    2);
    addRow(0, 1, 0, 0,     0, 0,            0,    16);
    addRow(0, 1, 0, 0,     0, 0,            0,    17);
    addRow(0, 1, 0, 0,     1, 'hA000_0010,  'h40, 18);
    addRow(0, 1, 0, 0,     1, 'hA000_0011,  'h44, 19);
    // Back-to-back redirects: only the last target is fetched.
    addRow(1, 1, 0, 0,     0, 0,            0,    0);
    addRow(0, 1, 0, 0,     0, 0,            0,    1);
    addRow(0, 0, 1, 'h40,  1, 'h66,         0,    2);
    addRow(0, 1, 1, 'h81,  0, 0,            0,    16);
    addRow(0, 1, 0, 0,     0, 0,            0,    32);
    addRow(0, 1, 0, 0,     0, 0,            0,    33);
    addRow(0, 1, 0, 0,     1, 'hA000_0020,  'h80, 34);
    // PC wrap from the top word to zero.
    addRow(1, 1, 0, 0,                      0, 0,            0,                       0);
    addRow(0, 1, 0, 0,                      0, 0,            0,                       1);
    addRow(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1, 'h66,         0,                       2);
    addRow(0, 1, 0, 0,                      0, 0,            0,                       64'h3FFF_FFFF_FFFF_FFFF);
    addRow(0, 1, 0, 0,                      0, 0,            0,                       0);
    addRow(0, 1, 0, 0,                      1, 'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFC, 1);
    addRow(0, 1, 0, 0,                      1, 'h66,         0,                       2);

    foreach (vecs[i]) begin
      if (vecs[i].first) doReset();
      else @(negedge clock);
      checkOutput(i, vecs[i]);
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset pulse placed between clock edges in the middle of a stream.
    doReset();
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    checkVal("async pre out_valid", {63'd0, ifc.out_valid}, 64'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkVal("async out_valid", {63'd0, ifc.out_valid}, 64'd0);
    checkVal("async imem_addr", ifc.imem_addr, 64'd0);
    checkVal("async out_inst", {32'd0, ifc.out_inst}, 64'd0);
    checkVal("async out_pc", ifc.out_pc, 64'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    checkVal("resume0 out_valid", {63'd0, ifc.out_valid}, 64'd0);
    checkVal("resume0 imem_addr", ifc.imem_addr, 64'd0);
    @(negedge clock);
    checkVal("resume1 imem_addr", ifc.imem_addr, 64'd1);
    @(negedge clock);
    checkVal("resume2 out_valid", {63'd0, ifc.out_valid}, 64'd1);
    checkVal("resume2 out_inst", {32'd0, ifc.out_inst}, 64'h66);
    checkVal("resume2 out_pc", ifc.out_pc, 64'd0);

`ifdef FETCH_PERF_CNT_EN
    // Ten edges with ready low on edges 3..5: three stalls and seven issues.
    doReset();
    checkVal("perf reset issue", {32'd0, perfIssue}, 64'd0);
    checkVal("perf reset stall", {32'd0, perfStall}, 64'd0);
    for (int k = 1; k <= 10; k++) begin
      ifc.out_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      @(negedge clock);
    end
    checkVal("perf issue count", {32'd0, perfIssue}, 64'd7);
    checkVal("perf stall count", {32'd0, perfStall}, 64'd3);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
